// File: rtl/lfsr_pkg.sv
// Shared types and defaults for the LFSR word collector and its FIFO.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    RESEED_WAIT
  } state_e;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEPTH  = 4;
  localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/rng_word_fifo.sv
// Synchronous WIDTH x DEPTH word FIFO. A push is accepted when there is room,
// or when the FIFO is full and a pop frees a slot on the same edge.
module rng_word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // NOTE: storage is not reset; the empty flag masks stale contents, so only
  // pointers and count need a reset value.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW + 1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW + 1)'(1);
    end
  end

endmodule

// File: rtl/lfsr_word_collector.sv
// Packs the LFSR serial stream into words, buffers them, and requests a reseed
// when too many identical consecutive words indicate a stuck generator.
module lfsr_word_collector
  import lfsr_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int REPEAT_LIMIT = 4,
  parameter int SETTLE       = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  output logic [WIDTH-1:0]      word_out,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  reseed_req,
  output logic                  stuck,
  input  logic                  clear_stuck,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int BC_W = $clog2(WIDTH);
  localparam int RC_W = $clog2(REPEAT_LIMIT + 1);
  localparam int ST_W = $clog2(SETTLE + 1);
  localparam logic [BC_W-1:0] BC_LAST  = BC_W'(WIDTH - 1);
  localparam logic [RC_W-1:0] RC_LIMIT = RC_W'(REPEAT_LIMIT);
  localparam logic [ST_W-1:0] ST_LAST  = ST_W'(SETTLE - 1);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      acc_q, acc_d;
  logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]      prev_word_q, prev_word_d;
  logic                  prev_valid_q, prev_valid_d;
  logic [RC_W-1:0]       repeat_cnt_q, repeat_cnt_d, rep_next;
  logic [ST_W-1:0]       settle_cnt_q, settle_cnt_d;
  logic                  reseed_q, reseed_d;
  logic                  stuck_q, stuck_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [WIDTH-1:0] word_c;
  logic             word_push, word_pop;
  logic             fifo_full, fifo_empty;

  assign word_c     = {acc_q[WIDTH-2:0], bit_in};
  assign word_valid = ~fifo_empty;
  assign word_pop   = word_valid & word_ready;
  assign reseed_req = reseed_q;
  assign stuck      = stuck_q;
  assign drop_count = drop_cnt_q;

  rng_word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (word_push),
    .wr_data (word_c),
    .pop     (word_pop),
    .rd_data (word_out),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    state_d      = state_q;
    acc_d        = acc_q;
    bit_cnt_d    = bit_cnt_q;
    prev_word_d  = prev_word_q;
    prev_valid_d = prev_valid_q;
    repeat_cnt_d = repeat_cnt_q;
    settle_cnt_d = settle_cnt_q;
    reseed_d     = 1'b0;
    stuck_d      = stuck_q & ~clear_stuck;
    drop_cnt_d   = drop_cnt_q;
    word_push    = 1'b0;
    rep_next     = repeat_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (enable) state_d = COLLECT;
      end
      COLLECT: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (bit_valid) begin
          acc_d = word_c;
          if (bit_cnt_q == BC_LAST) begin
            bit_cnt_d = '0;
            word_push = 1'b1;
            rep_next  = (prev_valid_q && (word_c == prev_word_q))
                        ? repeat_cnt_q + RC_W'(1) : RC_W'(1);
            // A stuck verdict overrides a same-cycle clear_stuck.
            if (rep_next == RC_LIMIT) begin
              reseed_d     = 1'b1;
              stuck_d      = 1'b1;
              acc_d        = '0;
              repeat_cnt_d = '0;
              prev_valid_d = 1'b0;
              settle_cnt_d = '0;
              state_d      = RESEED_WAIT;
            end else begin
              repeat_cnt_d = rep_next;
              prev_word_d  = word_c;
              prev_valid_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end
      end
      RESEED_WAIT: begin
        if (settle_cnt_q == ST_LAST) begin
          settle_cnt_d = '0;
          state_d      = enable ? COLLECT : IDLE;
        end else begin
          settle_cnt_d = settle_cnt_q + ST_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (word_push && fifo_full && !word_pop && (drop_cnt_q != '1))
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      bit_cnt_q    <= '0;
      prev_word_q  <= '0;
      prev_valid_q <= 1'b0;
      repeat_cnt_q <= '0;
      settle_cnt_q <= '0;
      reseed_q     <= 1'b0;
      stuck_q      <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      bit_cnt_q    <= bit_cnt_d;
      prev_word_q  <= prev_word_d;
      prev_valid_q <= prev_valid_d;
      repeat_cnt_q <= repeat_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      reseed_q     <= reseed_d;
      stuck_q      <= stuck_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

endmodule
